// File: rtl/vendor_param.sv
// Parametrised vending controller: two coin inputs, credit accumulation up to
// PRICE, a one-cycle vend strobe, then surplus or refund paid out in UNIT pulses.
module vendor_param #(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned COIN_A   = 5,
  parameter int unsigned COIN_B   = 10,
  parameter int unsigned UNIT     = 5,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inx,
  input  logic                iny,
  input  logic                cancel,
  output logic                vend,
  output logic                change,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned     MAX_COIN  = (COIN_A > COIN_B) ? COIN_A : COIN_B;
  localparam int unsigned     UNIT_SAFE = (UNIT == 0) ? 1 : UNIT;
  localparam longint unsigned NEED      = 64'(PRICE) + 64'(MAX_COIN) - 64'd1;
  localparam bit CFG_OK =
      (UNIT != 0) && (PRICE != 0) && (COIN_A != 0) && (COIN_B != 0) &&
      (PRICE % UNIT_SAFE == 0) && (COIN_A % UNIT_SAFE == 0) &&
      (COIN_B % UNIT_SAFE == 0) && (CREDIT_W < 64) &&
      (NEED < (64'd1 << CREDIT_W));

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] COIN_A_C = CREDIT_W'(COIN_A);
  localparam logic [CREDIT_W-1:0] COIN_B_C = CREDIT_W'(COIN_B);
  localparam logic [CREDIT_W-1:0] UNIT_C   = CREDIT_W'(UNIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;

  // Coin value for this cycle; coin A wins over a simultaneous coin B.
  always_comb begin
    coin_val = '0;
    if (inx)      coin_val = COIN_A_C;
    else if (iny) coin_val = COIN_B_C;
  end

  // Next-state and next-credit logic.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    sum        = credit + coin_val;
    unique case (state)
      S_IDLE, S_COLLECT: begin
        if (cancel) begin
          if (sum != '0) begin
            credit_nxt = sum;
            state_nxt  = S_CHANGE;
          end
        end else if (sum >= PRICE_C) begin
          credit_nxt = sum;
          state_nxt  = S_VEND;
        end else if (sum != '0) begin
          credit_nxt = sum;
          state_nxt  = S_COLLECT;
        end
      end
      S_VEND: begin
        credit_nxt = credit - PRICE_C;
        state_nxt  = (credit_nxt != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        credit_nxt = credit - UNIT_C;
        if (credit == UNIT_C) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt  = S_IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  // State, credit and strobes registered together so outputs come from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      credit <= '0;
      vend   <= 1'b0;
      change <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      vend   <= (state_nxt == S_VEND);
      change <= (state_nxt == S_CHANGE);
      busy   <= (state_nxt == S_VEND) || (state_nxt == S_CHANGE);
    end
  end

  // Configuration sanity check, evaluated whenever reset is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (CFG_OK)
        else $error("vendor_param: illegal parameter set PRICE=%0d COIN_A=%0d COIN_B=%0d UNIT=%0d CREDIT_W=%0d",
                    PRICE, COIN_A, COIN_B, UNIT, CREDIT_W);
    end
  end

endmodule

// File: tb/tb_vendor_param.sv
// Directed bench for vendor_param: default and PRICE=25 instances, scoreboard of
// hand-derived expected outputs checked one cycle after each stimulus step.
module tb_vendor_param;

  logic       clk = 1'b0;
  logic       rst_a, inx_a, iny_a, cancel_a;
  logic       vend_a, change_a, busy_a;
  logic [5:0] credit_a;
  logic       rst_b, inx_b, iny_b, cancel_b;
  logic       vend_b, change_b, busy_b;
  logic [5:0] credit_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         dut;
    logic       v;
    logic       c;
    logic       b;
    logic [5:0] cr;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  vendor_param u_def (
    .clk(clk), .rst(rst_a), .inx(inx_a), .iny(iny_a), .cancel(cancel_a),
    .vend(vend_a), .change(change_a), .busy(busy_a), .credit(credit_a)
  );

  vendor_param #(.PRICE(25), .COIN_A(10), .COIN_B(20), .UNIT(5), .CREDIT_W(6)) u_p25 (
    .clk(clk), .rst(rst_b), .inx(inx_b), .iny(iny_b), .cancel(cancel_b),
    .vend(vend_b), .change(change_b), .busy(busy_b), .credit(credit_b)
  );

  // One clock: drive inputs, queue expected outputs for the next cycle, compare.
  task automatic step(input bit dut, input logic r, input logic x, input logic y,
                      input logic c, input logic ev, input logic ec, input logic eb,
                      input logic [5:0] ecr, input string tag);
    exp_t e;
    logic       ov, oc, ob;
    logic [5:0] ocr;
    if (dut) begin
      rst_b = r; inx_b = x; iny_b = y; cancel_b = c;
    end else begin
      rst_a = r; inx_a = x; iny_a = y; cancel_a = c;
    end
    sb.push_back('{dut, ev, ec, eb, ecr, tag});
    @(posedge clk);
    #1;
    rst_a = 1'b0; inx_a = 1'b0; iny_a = 1'b0; cancel_a = 1'b0;
    rst_b = 1'b0; inx_b = 1'b0; iny_b = 1'b0; cancel_b = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    if (e.dut) begin
      ov = vend_b; oc = change_b; ob = busy_b; ocr = credit_b;
    end else begin
      ov = vend_a; oc = change_a; ob = busy_a; ocr = credit_a;
    end
    assert ({ov, oc, ob, ocr} === {e.v, e.c, e.b, e.cr})
      else begin
        errors++;
        $error("FAIL %s: got vend=%b change=%b busy=%b credit=%0d, expected vend=%b change=%b busy=%b credit=%0d",
               e.tag, ov, oc, ob, ocr, e.v, e.c, e.b, e.cr);
      end
  endtask

  initial begin
    rst_a = 1'b1; inx_a = 1'b0; iny_a = 1'b0; cancel_a = 1'b0;
    rst_b = 1'b1; inx_b = 1'b0; iny_b = 1'b0; cancel_b = 1'b0;
    #2;
    //    dut rst inx iny can  vend chg busy credit
    step(0, 1, 0, 0, 0, 0, 0, 0, 6'd0,  "reset_def");
    step(1, 1, 0, 0, 0, 0, 0, 0, 6'd0,  "reset_p25");

    // Three A coins reach the price exactly: vend, no change.
    step(0, 0, 1, 0, 0, 0, 0, 0, 6'd5,  "t1_c0_inx");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'd5,  "t1_c1_hold");
    step(0, 0, 1, 0, 0, 0, 0, 0, 6'd10, "t1_c2_inx");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'd10, "t1_c3_hold");
    step(0, 0, 1, 0, 0, 1, 0, 1, 6'd15, "t1_c5_vend");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'd0,  "t1_c6_idle");

    // Two B coins overpay by one unit; cancel during change is ignored.
    step(0, 0, 0, 1, 0, 0, 0, 0, 6'd10, "t2_c0_iny");
    step(0, 0, 0, 1, 0, 1, 0, 1, 6'd20, "t2_c2_vend");
    step(0, 0, 0, 0, 0, 0, 1, 1, 6'd5,  "t2_c3_change");
    step(0, 0, 0, 0, 1, 0, 0, 0, 6'd0,  "t2_c4_idle");

    // Simultaneous coins: A wins, B dropped.
    step(0, 0, 1, 1, 0, 0, 0, 0, 6'd5,  "t3_both");
    step(0, 0, 0, 1, 0, 1, 0, 1, 6'd15, "t3_vend");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'd0,  "t3_idle");

    // Cancel refunds in two pulses; a coin while busy is lost.
    step(0, 0, 0, 1, 0, 0, 0, 0, 6'd10, "t4_iny");
    step(0, 0, 0, 0, 1, 0, 1, 1, 6'd10, "t4_cancel_p1");
    step(0, 0, 1, 0, 0, 0, 1, 1, 6'd5,  "t4_p2_coin_lost");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'd0,  "t4_idle");
    step(0, 0, 0, 0, 1, 0, 0, 0, 6'd0,  "t4_cancel_empty");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'd0,  "t4_still_idle");
    // Coin with cancel in the same cycle is refunded too.
    step(0, 0, 1, 0, 1, 0, 1, 1, 6'd5,  "t4_coin_cancel");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'd0,  "t4_coin_cancel_idle");

    // PRICE=25: 20+20 vends at 40, three change pulses, coins lost meanwhile.
    step(1, 0, 0, 1, 0, 0, 0, 0, 6'd20, "t5_iny1");
    step(1, 0, 0, 1, 0, 1, 0, 1, 6'd40, "t5_vend40");
    step(1, 0, 1, 0, 0, 0, 1, 1, 6'd15, "t5_chg1");
    step(1, 0, 1, 0, 0, 0, 1, 1, 6'd10, "t5_chg2");
    step(1, 0, 1, 0, 0, 0, 1, 1, 6'd5,  "t5_chg3");
    step(1, 0, 0, 0, 0, 0, 0, 0, 6'd0,  "t5_idle");
    step(1, 0, 1, 0, 0, 0, 0, 0, 6'd10, "t5_new_coin");

    // Reset in the middle of a change train, then a clean sale.
    step(0, 0, 0, 1, 0, 0, 0, 0, 6'd10, "t6_iny");
    step(0, 0, 0, 0, 1, 0, 1, 1, 6'd10, "t6_cancel_p1");
    step(0, 1, 1, 0, 0, 0, 0, 0, 6'd0,  "t6_rst");
    step(0, 0, 1, 0, 0, 0, 0, 0, 6'd5,  "t6_inx");
    step(0, 0, 0, 1, 0, 1, 0, 1, 6'd15, "t6_vend");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'd0,  "t6_idle");

    checks++;
    assert (sb.size() == 0)
      else begin
        errors++;
        $error("FAIL sb_drain: got %0d leftover entries, expected 0", sb.size());
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
